// File: rtl/pipeline_types.sv
// Shared pipeline types: 32-bit bus word and the fetch-to-decode buffer entry.
// Exception field widths live here so icache and inst_buffer agree on them.
package pipeline_types;

  typedef logic [31:0] bus32_t;

  localparam int unsigned ExcWidth      = 6;
  localparam int unsigned ExcCauseWidth = 42;

  typedef struct packed {
    bus32_t                   pc;
    bus32_t                   inst;
    logic [ExcWidth-1:0]      is_exception;
    logic [ExcCauseWidth-1:0] exception_cause;
  } inst_buffer_entry_t;

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch-to-decode handshake bundle for inst_buffer.
// slave = buffer side, master = icache/decode/pipeline-control side.
interface inst_buffer_if
  import pipeline_types::*;
#(
  parameter int unsigned DEPTH = 8
);

  logic                     flush;
  logic                     in_valid;
  inst_buffer_entry_t       in_entry;
  logic                     full;
  logic                     almost_full;
  logic                     out_valid;
  inst_buffer_entry_t       out_entry;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  flush, in_valid, in_entry, out_ready,
    output full, almost_full, out_valid, out_entry, count
  );

  modport master (
    output flush, in_valid, in_entry, out_ready,
    input  full, almost_full, out_valid, out_entry, count
  );

endinterface

// File: rtl/inst_buffer.sv
// Circular instruction FIFO between icache and decode; flush has top priority.
// Optional zero-latency empty-path bypass enabled by defining INST_BUFFER_BYPASS_EN.
module inst_buffer
  import pipeline_types::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input logic           clk,
  input logic           reset,
  inst_buffer_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
  localparam logic [CW-1:0] AlmostC = CW'(DEPTH - 2);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("inst_buffer: DEPTH must be a power of two and at least 4");
  end

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  inst_buffer_entry_t mem_q [DEPTH];

  logic empty, full, push, pop_mem, bypass_take;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == DepthC);
`ifdef INST_BUFFER_BYPASS_EN
    bypass_take = empty && bus.in_valid && !bus.flush;
`else
    bypass_take = 1'b0;
`endif
    // A bypassed entry consumed the same cycle never enters storage.
    push    = bus.in_valid && !full && !(bypass_take && bus.out_ready);
    pop_mem = !empty && bus.out_ready;
  end

  always_comb begin
    bus.full        = full;
    bus.almost_full = (count_q >= AlmostC);
    bus.out_valid   = !empty || bypass_take;
    bus.count       = count_q;
    if (!empty) begin
      bus.out_entry = mem_q[rd_ptr_q];
    end else if (bypass_take) begin
      bus.out_entry = bus.in_entry;
    end else begin
      bus.out_entry = '0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop_mem);
    count_d  = count_q + CW'(push) - CW'(pop_mem);
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; out_entry masks it while empty.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      mem_q[wr_ptr_q] <= bus.in_entry;
    end
  end

endmodule

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning entry count; it must be a power of two and at least 4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-low reset (0 = reset).
REQ-004 SHALL have port flush, input, 1: branch_flush OR ctrl.exception_flush, driven by the pipeline.
REQ-005 SHALL have port in_valid, input, 1: icache presents an entry (icache_is_valid).
REQ-006 SHALL have port in_entry, input, inst_buffer_entry_t: pc 32, inst 32, is_exception 6, exception_cause 42.
REQ-007 SHALL have port full, output, 1: set when count == DEPTH.
REQ-008 SHALL have port almost_full, output, 1: set when count >= DEPTH-2; feeds icache stall_for_buffer, giving two cycles of slack.
REQ-009 SHALL have port out_valid, output, 1: the head entry is available to decode.
REQ-010 SHALL have port out_entry, output, inst_buffer_entry_t: the head entry.
REQ-011 SHALL have port out_ready, input, 1: decode accepts the head (low during ctrl.pause on the decode stage).
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1: current occupancy.

Function
REQ-013 SHALL be a circular FIFO with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
REQ-014 SHALL treat push = in_valid && !full, independent of pop in the same cycle.
REQ-015 SHALL drop an in_valid arriving while full, with no state change; upstream must honour almost_full.
REQ-016 SHALL treat pop = out_valid && out_ready.
REQ-017 SHALL update count as count + push - pop; push and pop in the same cycle leave count unchanged.
REQ-018 SHALL make out_valid = (count != 0), with out_entry = mem[rd_ptr], combinational from registered state.
REQ-019 SHALL give a pushed entry a latency to out_valid of one cycle (non-bypass build).
REQ-020 SHALL apply flush with highest priority: next cycle wr_ptr=0, rd_ptr=0, count=0, and any same-cycle push or pop is discarded.
REQ-021 SHALL store entries with is_exception != 0 and pass them through unmodified; no inst filtering is done.
REQ-022 SHALL hold out_entry stable while out_valid && !out_ready.

Reset
REQ-023 SHALL, while reset==0 at a clock edge: set wr_ptr=0, rd_ptr=0, count=0, out_valid=0, full=0, almost_full=0.
REQ-024 SHALL drive out_entry to all zeros while count==0; memory contents are not reset.
REQ-025 SHALL let reset override flush, push and pop; a reset during operation discards all entries.

Configuration
REQ-026 SHALL support macro INST_BUFFER_BYPASS_EN.
REQ-027 SHALL, when INST_BUFFER_BYPASS_EN is defined, present in_entry directly on out_entry with out_valid=1 when count==0 && in_valid && !flush (same-cycle, zero latency).
REQ-028 SHALL, in a bypass build, not store an entry taken through bypass with out_ready=1; with out_ready=0 it is stored normally.
REQ-029 SHALL, when INST_BUFFER_BYPASS_EN is undefined, have no bypass path; latency is per REQ-019.

Structure
REQ-030 SHALL define typedef inst_buffer_entry_t (packed: pc, inst, is_exception, exception_cause) in package pipeline_types, beside bus32_t.
REQ-031 SHALL place the exception field widths as constants in pipeline_types, shared with icache.
REQ-032 SHALL need no sub-module; storage is an inline register array of DEPTH entries.

Verification
REQ-033 SHALL pass: push pc 0x1C000000..0x1C00001C (8 entries, DEPTH=8), out_ready=0 -> count=8, full=1, almost_full=1 from count 6; a 9th push is dropped.
REQ-034 SHALL pass: continue REQ-033 with out_ready=1 for 8 cycles -> out_entry.pc 0x1C000000 then +4 in order; out_valid=0 after; pointers wrap.
REQ-035 SHALL pass: at count=4, push and pop in the same cycle -> count stays 4; the popped pc is the oldest.
REQ-036 SHALL pass: at count=5, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0; the flushed-cycle entry is absent.
REQ-037 SHALL pass: push inst 0x02800C21 with is_exception=6'b000100 -> output shows identical fields one cycle later (bypass build: same cycle when empty).
REQ-038 SHALL pass: reset=0 mid-stream with count=3 -> next cycle count=0, out_valid=0, out_entry=0.
